// File: rtl/cmdparser_gen2.sv
// cmdparser_gen2: forward-link command parser with opcode decode, packet-length tracking
// and Query field capture with CRC-5 gated commit of the transmitter settings.
`default_nettype none

module cmdparser_gen2 #(
  parameter int CNT_W      = 7,
  parameter int LEN_SELECT = 45,
  parameter int LEN_READ   = 58,
  parameter int LEN_WRITE  = 59,
  parameter int LEN_TRANS  = 10,
  parameter int EN_TRANS   = 1
) (
  input  logic             bitclk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             bitin,
  output logic [9:0]       cmd_out,
  output logic             cmd_complete,
  output logic             packet_complete,
  output logic             cmd_err,
  output logic             crc_ok,
  output logic [CNT_W-1:0] bit_count,
  output logic             dr,
  output logic [1:0]       m,
  output logic             trext,
  output logic [1:0]       sel,
  output logic [1:0]       session,
  output logic             target,
  output logic [3:0]       q
);

  typedef enum logic [1:0] {
    OPC  = 2'd0,
    BODY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [4:0]       CRC_PRESET = 5'b01001;

  state_t      state, state_next;
  logic [6:0]  opc_sr;
  logic [7:0]  opc_next;
  logic [4:0]  crc, crc_next;
  logic        crc_fb;
  logic [9:0]  dec_cmd;
  logic        dec_err, load_cmd, done_now;
  logic [31:0] cur_len, count_p1;

  logic       sh_dr, sh_trext, sh_target;
  logic [1:0] sh_m, sh_sel, sh_session;
  logic [3:0] sh_q;

  function automatic logic [31:0] cmd_len(input logic [9:0] c);
    logic [31:0] l;
    l = 32'd0;
    if (c[0]) l = 32'd4;
    if (c[1]) l = 32'd18;
    if (c[2]) l = 32'd22;
    if (c[3]) l = 32'd9;
    if (c[4]) l = 32'(LEN_SELECT);
    if (c[5]) l = 32'd8;
    if (c[6]) l = 32'd40;
    if (c[7]) l = 32'(LEN_READ);
    if (c[8]) l = 32'(LEN_WRITE);
    if (c[9]) l = 32'(LEN_TRANS);
    return l;
  endfunction

  // Opcode bits accumulate MSB-first, so the newest bit is always at [0]
  assign opc_next = {opc_sr, bitin};
  assign count_p1 = 32'(bit_count) + 32'd1;
  assign crc_fb   = bitin ^ crc[4];
  assign crc_next = {crc[3:0], 1'b0} ^ (crc_fb ? 5'b01001 : 5'b00000);
  assign cmd_complete = |cmd_out;

  always_ff @(posedge bitclk or negedge reset) begin
    if (!reset) state <= OPC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    dec_cmd    = '0;
    dec_err    = 1'b0;
    load_cmd   = 1'b0;
    done_now   = 1'b0;
    cur_len    = cmd_len(cmd_out);
    if (frame_start) begin
      state_next = OPC;
    end else begin
      case (state)
        OPC: begin
          if (bit_count == CNT_W'(1) && !opc_next[1]) begin
            dec_cmd = opc_next[0] ? 10'b00_0000_0010 : 10'b00_0000_0001;
          end else if (bit_count == CNT_W'(3) && opc_next[3:2] == 2'b10) begin
            case (opc_next[1:0])
              2'b00:   dec_cmd[2] = 1'b1;
              2'b01:   dec_cmd[3] = 1'b1;
              2'b10:   dec_cmd[4] = 1'b1;
              default: dec_err    = 1'b1;
            endcase
          end else if (bit_count == CNT_W'(7) && opc_next[7:6] == 2'b11) begin
            case (opc_next)
              8'hC0:   dec_cmd[5] = 1'b1;
              8'hC1:   dec_cmd[6] = 1'b1;
              8'hC2:   dec_cmd[7] = 1'b1;
              8'hC3:   dec_cmd[8] = 1'b1;
              8'hDA: begin
                if (EN_TRANS != 0) dec_cmd[9] = 1'b1;
                else               dec_err    = 1'b1;
              end
              default: dec_err    = 1'b1;
            endcase
          end
          if (dec_err) begin
            state_next = ERR;
          end else if (|dec_cmd) begin
            load_cmd = 1'b1;
            cur_len  = cmd_len(dec_cmd);
            if (count_p1 >= cur_len) begin
              done_now   = 1'b1;
              state_next = DONE;
            end else begin
              state_next = BODY;
            end
          end
        end
        BODY: begin
          if (count_p1 == cur_len) begin
            done_now   = 1'b1;
            state_next = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bitclk or negedge reset) begin
    if (!reset) begin
      cmd_out         <= '0;
      packet_complete <= 1'b0;
      cmd_err         <= 1'b0;
      crc_ok          <= 1'b0;
      bit_count       <= '0;
      opc_sr          <= '0;
      crc             <= CRC_PRESET;
      {sh_dr, sh_m, sh_trext, sh_sel, sh_session, sh_target, sh_q} <= '0;
      {dr, m, trext, sel, session, target, q}                       <= '0;
    end else if (frame_start) begin
      cmd_out         <= '0;
      packet_complete <= 1'b0;
      cmd_err         <= 1'b0;
      bit_count       <= '0;
      opc_sr          <= '0;
      crc             <= CRC_PRESET;
      {sh_dr, sh_m, sh_trext, sh_sel, sh_session, sh_target, sh_q} <= '0;
    end else begin
      if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_W'(1);
      opc_sr <= opc_next[6:0];
      if (count_p1 <= 32'd22) crc <= crc_next;
      if (load_cmd) cmd_out <= dec_cmd;
      if (dec_err)  cmd_err <= 1'b1;
      if (done_now) packet_complete <= 1'b1;
      if (state == BODY && cmd_out[2]) begin
        case (32'(bit_count))
          32'd4:   sh_dr         <= bitin;
          32'd5:   sh_m[1]       <= bitin;
          32'd6:   sh_m[0]       <= bitin;
          32'd7:   sh_trext      <= bitin;
          32'd8:   sh_sel[1]     <= bitin;
          32'd9:   sh_sel[0]     <= bitin;
          32'd10:  sh_session[1] <= bitin;
          32'd11:  sh_session[0] <= bitin;
          32'd12:  sh_target     <= bitin;
          32'd13:  sh_q[3]       <= bitin;
          32'd14:  sh_q[2]       <= bitin;
          32'd15:  sh_q[1]       <= bitin;
          32'd16:  sh_q[0]       <= bitin;
          default: ;
        endcase
        // The residue must include the final CRC bit sampled on this edge
        if (done_now) begin
          if (crc_next == 5'b00000) begin
            {dr, m, trext, sel, session, target, q} <=
              {sh_dr, sh_m, sh_trext, sh_sel, sh_session, sh_target, sh_q};
            crc_ok <= 1'b1;
          end else begin
            crc_ok <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
